fit_out_fsm: RTL and testbench
==============================

FIT_OUT_FSM -- requirements
Module: fit_out_fsm

Interface
REQ-001 SHALL have ports: clock  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high.
REQ-003 SHALL have ports: output_enable  input  1  permits new road/trailer start.
REQ-004 SHALL have ports: comb_empty  input  1; comb_data  input  30  fit word; comb_eor  input  1  last fit of road; comb_ee  input  1  end-event marker word (comb_data[7:0] = event tag).
REQ-005 SHALL have ports: comb_re  output  1  pop combination FIFO (FWFT: data valid while ~comb_empty).
REQ-006 SHALL have ports: roadid_empty  input  1; roadid_data  input  21; roadid_re  output  1  pop road-ID FIFO (FWFT).
REQ-007 SHALL have ports: out_hold  input  1  downstream backpressure.
REQ-008 SHALL have ports: out_data  output  32; out_dv  output  1; out_ep  output  1  end of road; out_ee  output  1  end of event; err  output  1  sticky protocol error.
REQ-009 SHALL have parameters: none.

Function
REQ-010 SHALL implement states IDLE, HEADER, FIT, TRAILER; encoding free, unreachable encodings SHALL return to IDLE.
REQ-011 out_data/out_dv/out_ep/out_ee SHALL be registered: word popped in cycle N appears on outputs in cycle N+1; out_dv=0 in any cycle following a cycle with no pop.
REQ-012 comb_re and roadid_re SHALL be combinational from state and inputs, and SHALL never assert while out_hold=1 or the respective FIFO is empty.
REQ-013 IDLE: if output_enable & ~out_hold & ~comb_empty & comb_ee -> TRAILER; else if output_enable & ~out_hold & ~comb_empty & ~comb_ee & ~roadid_empty -> HEADER; else stay.
REQ-014 HEADER: if ~out_hold: roadid_re=1, emit out_data={11'h000, roadid_data}, out_ep=out_ee=0, road_cnt+1 (saturate 8'hFF), -> FIT; if out_hold stay.
REQ-015 FIT, ~comb_empty & ~comb_ee & ~out_hold: comb_re=1, emit {2'b00, comb_data}, word_cnt+1 (saturate 16'hFFFF), out_ep=comb_eor; comb_eor -> IDLE, else stay.
REQ-016 FIT, comb_empty or out_hold: no pop, stay in FIT.
REQ-017 FIT, ~comb_empty & comb_ee (marker before eor): set err, no pop, no output, -> IDLE (trailer then emitted normally).
REQ-018 TRAILER: if ~out_hold: comb_re=1, emit out_data={road_cnt, word_cnt, comb_data[7:0]}, out_ee=1, out_ep=0; next cycle road_cnt=0, word_cnt=0; -> IDLE. If out_hold stay.
REQ-019 Counter update and trailer emission in same cycle: trailer SHALL carry pre-clear values.
REQ-020 output_enable SHALL only gate starts from IDLE; a road in progress SHALL complete regardless.
REQ-021 comb_ee marker with roadid_empty in IDLE SHALL still start TRAILER; non-ee comb word with roadid_empty SHALL wait in IDLE.
REQ-022 err SHALL remain 1 until reset.

Reset
REQ-023 On reset: state IDLE, out_data=0, out_dv=0, out_ep=0, out_ee=0, err=0, road_cnt=0, word_cnt=0; comb_re=roadid_re=0 during reset.
REQ-024 Reset mid-road SHALL abandon the road without further pops; FIFO contents are not touched by this block.

Verification
REQ-025 Road 0x1ABCD + fits 0x111,0x222(eor) + ee tag 0x5A, no hold -> out words 0x0001ABCD, 0x00000111, 0x00000222(ep), 0x01 0002 5A(ee), each dv one cycle.
REQ-026 Same stimulus, out_hold=1 for 3 cycles during FIT -> no pops/dv during hold, identical output sequence, resumes cycle after hold drops.
REQ-027 ee marker while in FIT after 1 fit -> err=1, no ep, trailer {0x01,0x0001,tag}, err stays 1.
REQ-028 output_enable=0 with full FIFOs -> no pops, out_dv=0; deassert mid-road -> road finishes, next road waits.
REQ-029 300 roads of one fit in one event -> trailer road_cnt=0xFF (saturated), word_cnt=300.
REQ-030 Reset asserted in FIT -> next cycle all outputs 0, IDLE; fresh road after reset output correctly, counters from 0.

Source files
------------

// File: rtl/fit_out_fsm_if.sv
// rtl/fit_out_fsm_if.sv - handshake/bus bundle between fit_out_fsm and its FIFOs/downstream
//
// Purpose: groups the combination FIFO, road-ID FIFO and output-stream signals of
//          fit_out_fsm so they travel as one port.
// Signals:
//   output_enable       permits a new road/trailer start
//   comb_empty/data/eor/ee, comb_re     combination FIFO (first-word fall-through)
//   roadid_empty/data, roadid_re        road-ID FIFO (first-word fall-through)
//   out_hold                            downstream backpressure
//   out_data/dv/ep/ee, err              registered output word, flags, sticky error
// Modports: master = fit_out_fsm side, slave = FIFO/downstream side.
interface fit_out_fsm_if;
   logic        output_enable;
   logic        comb_empty;
   logic [29:0] comb_data;
   logic        comb_eor;
   logic        comb_ee;
   logic        comb_re;
   logic        roadid_empty;
   logic [20:0] roadid_data;
   logic        roadid_re;
   logic        out_hold;
   logic [31:0] out_data;
   logic        out_dv;
   logic        out_ep;
   logic        out_ee;
   logic        err;

   modport master (
      input  output_enable, comb_empty, comb_data, comb_eor, comb_ee,
             roadid_empty, roadid_data, out_hold,
      output comb_re, roadid_re, out_data, out_dv, out_ep, out_ee, err
   );

   modport slave (
      output output_enable, comb_empty, comb_data, comb_eor, comb_ee,
             roadid_empty, roadid_data, out_hold,
      input  comb_re, roadid_re, out_data, out_dv, out_ep, out_ee, err
   );
endinterface

// File: rtl/fit_out_fsm.sv
// rtl/fit_out_fsm.sv - frames roads (header + fits) and per-event trailers onto the output stream
//
// Purpose: pops a road ID and its fits from two FWFT FIFOs, emits header/fit words,
//          and on an end-event marker emits a trailer carrying road and fit counts.
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high
//   bus     fit_out_fsm_if.master (FIFO pops, output stream, sticky err)
module fit_out_fsm (
   input  logic          clock,
   input  logic          reset,
   fit_out_fsm_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      FIT     = 2'd2,
      TRAILER = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  road_cnt;
   logic [15:0] word_cnt;

   logic        hdr_pop;
   logic        fit_pop;
   logic        trl_pop;
   logic        fit_err;
   logic [31:0] word_next;
   logic        ep_next;
   logic        ee_next;

   always_comb begin
      state_next = state;
      hdr_pop    = 1'b0;
      fit_pop    = 1'b0;
      trl_pop    = 1'b0;
      fit_err    = 1'b0;
      word_next  = 32'h0;
      ep_next    = 1'b0;
      ee_next    = 1'b0;

      case (state)
         IDLE: begin
            // An end-event marker starts a trailer even with no road ID queued.
            if (bus.output_enable && !bus.out_hold && !bus.comb_empty) begin
               if (bus.comb_ee)
                  state_next = TRAILER;
               else if (!bus.roadid_empty)
                  state_next = HEADER;
            end
         end
         HEADER: begin
            if (!bus.out_hold && !bus.roadid_empty) begin
               hdr_pop    = 1'b1;
               word_next  = {11'h000, bus.roadid_data};
               state_next = FIT;
            end
         end
         FIT: begin
            if (!bus.out_hold && !bus.comb_empty) begin
               if (bus.comb_ee) begin
                  // Marker arrived before end-of-road: flag it and let IDLE
                  // pick the marker up as a normal trailer.
                  fit_err    = 1'b1;
                  state_next = IDLE;
               end else begin
                  fit_pop   = 1'b1;
                  word_next = {2'b00, bus.comb_data};
                  ep_next   = bus.comb_eor;
                  if (bus.comb_eor)
                     state_next = IDLE;
               end
            end
         end
         TRAILER: begin
            if (!bus.out_hold && !bus.comb_empty) begin
               trl_pop    = 1'b1;
               word_next  = {road_cnt, word_cnt, bus.comb_data[7:0]};
               ee_next    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (reset) begin
         hdr_pop = 1'b0;
         fit_pop = 1'b0;
         trl_pop = 1'b0;
         fit_err = 1'b0;
      end
   end

   assign bus.roadid_re = hdr_pop;
   assign bus.comb_re   = fit_pop | trl_pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         bus.out_data <= 32'h0;
         bus.out_dv   <= 1'b0;
         bus.out_ep   <= 1'b0;
         bus.out_ee   <= 1'b0;
         bus.err      <= 1'b0;
         road_cnt     <= 8'h00;
         word_cnt     <= 16'h0000;
      end else begin
         state      <= state_next;
         bus.out_dv <= hdr_pop | fit_pop | trl_pop;
         bus.out_ep <= ep_next;
         bus.out_ee <= ee_next;
         if (hdr_pop | fit_pop | trl_pop)
            bus.out_data <= word_next;
         if (fit_err)
            bus.err <= 1'b1;

         // The trailer word is built from the current counts in the same
         // cycle they are cleared, so it carries the pre-clear values.
         if (trl_pop) begin
            road_cnt <= 8'h00;
            word_cnt <= 16'h0000;
         end else begin
            if (hdr_pop && road_cnt != 8'hFF)
               road_cnt <= road_cnt + 8'h01;
            if (fit_pop && word_cnt != 16'hFFFF)
               word_cnt <= word_cnt + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_fit_out_fsm.sv
// tb/tb_fit_out_fsm.sv - self-checking bench for fit_out_fsm against a stream-level model
module tb_fit_out_fsm;

   typedef struct packed {
      logic        ee;
      logic        eor;
      logic [29:0] data;
   } comb_t;

   typedef struct packed {
      logic [31:0] data;
      logic        ep;
      logic        ee;
   } out_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fit_out_fsm_if bus ();

   fit_out_fsm dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   comb_t       pend_comb[$];
   comb_t       comb_q[$];
   logic [20:0] pend_road[$];
   logic [20:0] road_q[$];
   out_t        exp_q[$];

   int unsigned m_roads;
   int unsigned m_words;
   bit          in_road;
   bit          exp_err;

   int  checks = 0;
   int  errors = 0;
   int  pops_seen = 0;
   bit  prev_pop = 1'b0;
   bit  prev_err = 1'b0;
   bit  cmp_en = 1'b0;
   int  hold_mode = 0;
   bit  en_random = 1'b0;
   bit  feed_all = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Stream-level model: each pushed item appends the words it must produce.
   task automatic push_road(input logic [20:0] id);
      pend_road.push_back(id);
      m_roads = (m_roads >= 255) ? 255 : m_roads + 1;
      exp_q.push_back({{11'h000, id}, 1'b0, 1'b0});
      in_road = 1'b1;
   endtask

   task automatic push_fit(input logic [29:0] data, input logic eor);
      pend_comb.push_back({1'b0, eor, data});
      m_words = (m_words >= 65535) ? 65535 : m_words + 1;
      exp_q.push_back({{2'b00, data}, eor, 1'b0});
      if (eor) in_road = 1'b0;
   endtask

   task automatic push_ee(input logic [7:0] tag);
      pend_comb.push_back({1'b1, 1'b0, 22'h0, tag});
      if (in_road) exp_err = 1'b1;
      in_road = 1'b0;
      exp_q.push_back({m_roads[7:0], m_words[15:0], tag, 1'b0, 1'b1});
      m_roads = 0;
      m_words = 0;
   endtask

   task automatic feed();
      if (feed_all) begin
         while (pend_comb.size() > 0) comb_q.push_back(pend_comb.pop_front());
         while (pend_road.size() > 0) road_q.push_back(pend_road.pop_front());
      end else begin
         if (pend_comb.size() > 0 && $urandom_range(0, 3) != 0) comb_q.push_back(pend_comb.pop_front());
         if (pend_road.size() > 0 && $urandom_range(0, 3) != 0) road_q.push_back(pend_road.pop_front());
      end
   endtask

   task automatic drive_fifo();
      logic [31:0] r;
      r = $urandom;
      if (comb_q.size() > 0) begin
         bus.comb_empty = 1'b0;
         bus.comb_data  = comb_q[0].data;
         bus.comb_eor   = comb_q[0].eor;
         bus.comb_ee    = comb_q[0].ee;
      end else begin
         bus.comb_empty = 1'b1;
         bus.comb_data  = r[29:0];
         bus.comb_eor   = r[30];
         bus.comb_ee    = r[31];
      end
      r = $urandom;
      if (road_q.size() > 0) begin
         bus.roadid_empty = 1'b0;
         bus.roadid_data  = road_q[0];
      end else begin
         bus.roadid_empty = 1'b1;
         bus.roadid_data  = r[20:0];
      end
   endtask

   task automatic compare();
      out_t e;
      if (!cmp_en) return;
      check("out_dv", bus.out_dv, prev_pop);
      if (bus.out_dv === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_ep", bus.out_ep, e.ep);
            check("out_ee", bus.out_ee, e.ee);
         end
      end
      if (prev_err) check("err_sticky", bus.err, 1);
      if (bus.err === 1'b1 && !exp_err) check("err_premature", bus.err, 0);
      prev_err = (bus.err === 1'b1);
   endtask

   // One clock: starts and ends at a falling edge.
   task automatic cycle();
      bit cpop;
      bit rpop;
      compare();
      case (hold_mode)
         0:       bus.out_hold = 1'b0;
         1:       bus.out_hold = 1'b1;
         default: bus.out_hold = ($urandom_range(0, 3) == 0);
      endcase
      if (en_random) bus.output_enable = ($urandom_range(0, 7) != 0);
      drive_fifo();
      #4;
      cpop = (bus.comb_re === 1'b1);
      rpop = (bus.roadid_re === 1'b1);
      if (cmp_en)
         check("re_guard",
               {cpop && (bus.out_hold || bus.comb_empty || reset),
                rpop && (bus.out_hold || bus.roadid_empty || reset)}, 0);
      @(posedge clock);
      if (cpop && comb_q.size() > 0) void'(comb_q.pop_front());
      if (rpop && road_q.size() > 0) void'(road_q.pop_front());
      prev_pop  = (cpop || rpop) && !reset;
      pops_seen += int'(cpop) + int'(rpop);
      feed();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hold_mode = 0;
      cycle();
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_flags", {bus.out_dv, bus.out_ep, bus.out_ee, bus.err}, 0);
      check("rst_re", {bus.comb_re, bus.roadid_re}, 0);
      pend_comb.delete();
      comb_q.delete();
      pend_road.delete();
      road_q.delete();
      exp_q.delete();
      m_roads  = 0;
      m_words  = 0;
      in_road  = 1'b0;
      exp_err  = 1'b0;
      prev_err = 1'b0;
      prev_pop = 1'b0;
      cmp_en   = 1'b1;
      reset    = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || comb_q.size() > 0 || road_q.size() > 0 ||
              pend_comb.size() > 0 || pend_road.size() > 0) && n < 20000) begin
         cycle();
         n++;
      end
      check({name, "_drained"}, exp_q.size() + comb_q.size() + road_q.size(), 0);
      cycle();
      cycle();
   endtask

   task automatic basic_road();
      push_road(21'h1ABCD);
      push_fit(30'h111, 1'b0);
      push_fit(30'h222, 1'b1);
      push_ee(8'h5A);
      feed();
   endtask

   initial begin
      logic [6:0]  dvh;
      logic [31:0] r;
      int          p0;
      int          nr;
      int          nf;
      bit          bad;

      bus.output_enable = 1'b1;
      bus.out_hold      = 1'b0;
      drive_fifo();
      @(negedge clock);

      // Plain road, no hold: literal pins plus exact dv timing.
      do_reset();
      basic_road();
      check("pin_hdr", {exp_q[0].data, exp_q[0].ep, exp_q[0].ee}, {32'h0001ABCD, 2'b00});
      check("pin_fit0", {exp_q[1].data, exp_q[1].ep, exp_q[1].ee}, {32'h00000111, 2'b00});
      check("pin_fit1", {exp_q[2].data, exp_q[2].ep, exp_q[2].ee}, {32'h00000222, 2'b10});
      check("pin_trl", {exp_q[3].data, exp_q[3].ep, exp_q[3].ee}, {32'h0100025A, 2'b01});
      for (int i = 0; i < 7; i++) begin
         dvh[6-i] = bus.out_dv;
         cycle();
      end
      check("dv_pattern", dvh, 7'b0011101);
      drain("basic");

      // Hold for three cycles while in FIT.
      do_reset();
      basic_road();
      cycle();
      cycle();
      p0 = pops_seen;
      hold_mode = 1;
      for (int i = 0; i < 3; i++) cycle();
      check("hold_no_pop", pops_seen - p0, 0);
      hold_mode = 0;
      cycle();
      check("hold_resume", pops_seen - p0, 1);
      drain("hold");

      // End-event marker in the middle of a road.
      do_reset();
      push_road(21'h00042);
      push_fit(30'h3333, 1'b0);
      push_ee(8'hC3);
      feed();
      check("pin_err_trl", {exp_q[2].data, exp_q[2].ep, exp_q[2].ee}, {32'h010001C3, 2'b01});
      check("pin_err_flag", exp_err, 1);
      drain("ee_in_fit");
      check("err_set", bus.err, 1);
      for (int i = 0; i < 5; i++) cycle();
      check("err_held", bus.err, 1);

      // output_enable gating.
      do_reset();
      bus.output_enable = 1'b0;
      push_road(21'h00AAA);
      push_fit(30'h1, 1'b0);
      push_fit(30'h2, 1'b1);
      push_road(21'h00BBB);
      push_fit(30'h3, 1'b1);
      push_ee(8'h01);
      feed();
      p0 = pops_seen;
      for (int i = 0; i < 20; i++) cycle();
      check("oe_no_pop", pops_seen - p0, 0);
      bus.output_enable = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      bus.output_enable = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      check("oe_road_done", exp_q.size(), 3);
      bus.output_enable = 1'b1;
      drain("oe");

      // 300 single-fit roads: road count saturates.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         push_road(21'(i));
         push_fit(30'(i + 7), 1'b1);
      end
      push_ee(8'h77);
      feed();
      check("pin_sat_trl", exp_q[exp_q.size()-1].data, 32'hFF012C77);
      drain("sat");

      // Reset in the middle of a road, then a fresh road.
      do_reset();
      push_road(21'h12345);
      push_fit(30'h10, 1'b0);
      push_fit(30'h20, 1'b0);
      push_fit(30'h30, 1'b1);
      push_ee(8'h22);
      feed();
      for (int i = 0; i < 4; i++) cycle();
      do_reset();
      push_road(21'h0F0F0);
      push_fit(30'h5, 1'b1);
      push_ee(8'h11);
      feed();
      check("pin_fresh_trl", exp_q[2].data, 32'h01000111);
      drain("post_reset");

      // Randomized traffic, backpressure, enable toggling and FIFO gaps.
      do_reset();
      feed_all  = 1'b0;
      hold_mode = 2;
      en_random = 1'b1;
      for (int e = 0; e < 40; e++) begin
         nr = $urandom_range(0, 3);
         for (int rd = 0; rd < nr; rd++) begin
            r = $urandom;
            push_road(r[20:0]);
            bad = (rd == nr - 1) && ($urandom_range(0, 7) == 0);
            nf = $urandom_range(1, bad ? 2 : 4);
            for (int f = 0; f < nf; f++) begin
               r = $urandom;
               push_fit(r[29:0], !bad && (f == nf - 1));
            end
         end
         r = $urandom;
         push_ee(r[7:0]);
      end
      drain("random");
      check("err_final", bus.err, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
